top_elastic_arb: RTL and testbench

TOP_ELASTIC_ARB -- requirements
Module: top_elastic_arb

---
 rtl/top_elastic_arb.sv | 141 ++++++++++++++
 tb/tb_top_elastic_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/top_elastic_arb.sv
// top_elastic_arb: four-requester round-robin arbiter feeding one registered elastic output stage.
// Define ELASTIC_ARB_PKT_LOCK_EN to keep the grant on one requester until its packet's last beat.
module top_elastic_arb #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstf,
  input  logic [DW-1:0] t0_data,
  input  logic [DW-1:0] t1_data,
  input  logic [DW-1:0] t2_data,
  input  logic [DW-1:0] t3_data,
  input  logic          t0_valid,
  input  logic          t1_valid,
  input  logic          t2_valid,
  input  logic          t3_valid,
  input  logic          t0_last,
  input  logic          t1_last,
  input  logic          t2_last,
  input  logic          t3_last,
  output logic          t0_ready,
  output logic          t1_ready,
  output logic          t2_ready,
  output logic          t3_ready,
  output logic [DW-1:0] i0_data,
  output logic          i0_valid,
  output logic          i0_last,
  output logic [1:0]    i0_src,
  input  logic          i0_ready
);

  logic [DW-1:0] w_data [4];
  logic [3:0]    w_valid;
  logic [3:0]    w_last;
  logic [3:0]    w_ready;
  logic [1:0]    w_grant;
  logic          w_accept;
  logic          w_xfer;

  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_last;
  logic [1:0]    r_src;
  logic [1:0]    r_ptr;

`ifdef ELASTIC_ARB_PKT_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t     r_state;
  logic [1:0] r_lockIdx;
`endif

  assign w_data[0] = t0_data;
  assign w_data[1] = t1_data;
  assign w_data[2] = t2_data;
  assign w_data[3] = t3_data;
  assign w_valid   = {t3_valid, t2_valid, t1_valid, t0_valid};
  assign w_last    = {t3_last, t2_last, t1_last, t0_last};
  assign w_accept  = ~r_valid | i0_ready;

  // Scan from the farthest offset down so the nearest valid requester above r_ptr wins.
  always_comb begin
    logic [1:0] idx;
    idx     = r_ptr;
    w_grant = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = r_ptr + 2'(k);
      if (w_valid[idx]) w_grant = idx;
    end
`ifdef ELASTIC_ARB_PKT_LOCK_EN
    if (r_state == LOCKED) w_grant = r_lockIdx;
`endif
  end

  always_comb begin
    w_ready          = '0;
    w_ready[w_grant] = rstf & w_accept;
  end

  assign w_xfer   = |(w_valid & w_ready);
  assign t0_ready = w_ready[0];
  assign t1_ready = w_ready[1];
  assign t2_ready = w_ready[2];
  assign t3_ready = w_ready[3];

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_src   <= 2'd0;
    end else if (w_accept) begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_data <= w_data[w_grant];
        r_last <= w_last[w_grant];
        r_src  <= w_grant;
      end
    end
  end

`ifdef ELASTIC_ARB_PKT_LOCK_EN
  // A packet that opens in ARB pins the grant until its last beat; the pointer then skips past it.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_ptr     <= 2'd0;
      r_state   <= ARB;
      r_lockIdx <= 2'd0;
    end else if (w_xfer) begin
      case (r_state)
        ARB: begin
          r_ptr <= w_grant + 2'd1;
          if (!w_last[w_grant]) begin
            r_state   <= LOCKED;
            r_lockIdx <= w_grant;
          end
        end
        LOCKED: begin
          if (w_last[w_grant]) begin
            r_state <= ARB;
            r_ptr   <= r_lockIdx + 2'd1;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      r_ptr <= 2'd0;
    end else if (w_xfer) begin
      r_ptr <= w_grant + 2'd1;
    end
  end
`endif

  assign i0_data  = r_data;
  assign i0_valid = r_valid;
  assign i0_last  = r_last;
  assign i0_src   = r_src;

endmodule

// File: tb/tb_top_elastic_arb.sv
// tb_top_elastic_arb: directed and randomized checks of top_elastic_arb against a beat-level model.
// Honours ELASTIC_ARB_PKT_LOCK_EN the same way as the design.
module tb_top_elastic_arb;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                rstf;
  logic [3:0][DW-1:0]  tData;
  logic [3:0]          tValid;
  logic [3:0]          tLast;
  logic                t0Ready, t1Ready, t2Ready, t3Ready;
  logic [DW-1:0]       i0Data;
  logic                i0Valid;
  logic                i0Last;
  logic [1:0]          i0Src;
  logic                i0Ready;

  int nErrors = 0;
  int nChecks = 0;

  // Beat-level reference state
  int            mPtr;
  bit            mLocked;
  int            mLockIdx;
  bit            mValid;
  logic [DW-1:0] mData;
  bit            mLast;
  int            mSrc;
  int            mXferSrc;
  int            obsSrc[$];

  top_elastic_arb #(.DW(DW)) dut (
    .clk(clk), .rstf(rstf),
    .t0_data(tData[0]), .t1_data(tData[1]), .t2_data(tData[2]), .t3_data(tData[3]),
    .t0_valid(tValid[0]), .t1_valid(tValid[1]), .t2_valid(tValid[2]), .t3_valid(tValid[3]),
    .t0_last(tLast[0]), .t1_last(tLast[1]), .t2_last(tLast[2]), .t3_last(tLast[3]),
    .t0_ready(t0Ready), .t1_ready(t1Ready), .t2_ready(t2Ready), .t3_ready(t3Ready),
    .i0_data(i0Data), .i0_valid(i0Valid), .i0_last(i0Last), .i0_src(i0Src),
    .i0_ready(i0Ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int firstValid(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic void modelReset();
    mPtr = 0; mLocked = 0; mLockIdx = 0;
    mValid = 0; mData = '0; mLast = 0; mSrc = 0; mXferSrc = -1;
  endfunction

  task automatic checkOutput();
    check("i0_valid", i0Valid, mValid);
    if (mValid) begin
      check("i0_data", i0Data, mData);
      check("i0_src", i0Src, mSrc);
      check("i0_last", i0Last, mLast);
    end
  endtask

  // One cycle: check held outputs, drive new inputs, check readies, advance the model.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                               input logic [3:0][DW-1:0] d, input logic rdy);
    logic [3:0] rdyObs;
    bit accept, anyXfer;
    int g;
    @(negedge clk);
    checkOutput();
    if (i0Valid && rdy) obsSrc.push_back(int'(i0Src));
    tValid = v; tLast = l; tData = d; i0Ready = rdy;
    #1;
    rdyObs = {t3Ready, t2Ready, t1Ready, t0Ready};
    accept = !mValid || rdy;
    if (mLocked) begin
      g = mLockIdx;
      anyXfer = accept && v[g];
    end else begin
      g = firstValid(v, mPtr);
      anyXfer = accept && (g >= 0);
    end
    check("readyOnehot", ($countones(rdyObs) <= 1), 1);
    for (int n = 0; n < 4; n++) begin
      if (mLocked || v[n])
        check($sformatf("ready%0d", n), rdyObs[n], (accept && n == g));
    end
    if (accept) begin
      mValid = anyXfer;
      if (anyXfer) begin
        mData = d[g]; mLast = l[g]; mSrc = g;
      end
    end
    mXferSrc = anyXfer ? g : -1;
    if (anyXfer) begin
`ifdef ELASTIC_ARB_PKT_LOCK_EN
      if (!mLocked) begin
        mPtr = (g + 1) % 4;
        if (!l[g]) begin
          mLocked = 1; mLockIdx = g;
        end
      end else if (l[g]) begin
        mLocked = 0;
        mPtr = (mLockIdx + 1) % 4;
      end
`else
      mPtr = (g + 1) % 4;
`endif
    end
  endtask

  // Pulse rstf low for one cycle while the given valids are held.
  task automatic doReset(input logic [3:0] vHeld);
    @(negedge clk);
    tValid = vHeld;
    rstf = 1'b0;
    #1;
    check("rstReadies", {t3Ready, t2Ready, t1Ready, t0Ready}, 4'b0000);
    check("rstValid", i0Valid, 0);
    check("rstData", i0Data, 0);
    check("rstSrc", i0Src, 0);
    check("rstLast", i0Last, 0);
    modelReset();
    @(negedge clk);
    rstf = 1'b1;
    tValid = '0;
  endtask

  function automatic logic [3:0][DW-1:0] dat(input logic [DW-1:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  initial begin
    int rem;
    int expSeq[5];
    rstf = 1'b0; tValid = '0; tLast = '0; tData = '0; i0Ready = 1'b0;
    modelReset();
    doReset(4'b0000);

    $display("[TB] all four valid, round-robin rotation");
    obsSrc.delete();
    for (int i = 0; i < 6; i++)
      applyStimulus(4'b1111, 4'b1111, dat(32'h10, 32'h11, 32'h12, 32'h13), 1'b1);
    expSeq = '{0, 1, 2, 3, 0};
    check("rotCount", obsSrc.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      if (obsSrc.size() > i) check($sformatf("rotSrc%0d", i), obsSrc[i], expSeq[i]);

    $display("[TB] stalled beat from t2");
    applyStimulus(4'b0000, 4'b0000, '0, 1'b1);
    applyStimulus(4'b0100, 4'b1111, dat(0, 0, 32'hA5A5A5A5, 0), 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'($urandom), 4'b1111, dat($urandom, $urandom, $urandom, $urandom), 1'b0);
      check("stallData", i0Data, 32'hA5A5A5A5);
      check("stallSrc", i0Src, 2);
    end
    applyStimulus(4'b0000, 4'b0000, '0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, '0, 1'b1);

    $display("[TB] three-beat packet from t1 while t0 and t3 compete");
    doReset(4'b0000);
    applyStimulus(4'b0001, 4'b0001, dat(32'h50, 0, 0, 0), 1'b1);
    obsSrc.delete();
    rem = 3;
    for (int i = 0; i < 8; i++) begin
      applyStimulus({1'b1, 1'b0, (rem > 0), 1'b1}, {1'b1, 1'b1, (rem == 1), 1'b1},
                    dat(32'h60 + i, 32'h24 - rem, 0, 32'h70 + i), 1'b1);
      if (mXferSrc == 1) rem--;
    end
`ifdef ELASTIC_ARB_PKT_LOCK_EN
    expSeq = '{0, 1, 1, 1, 3};
`else
    expSeq = '{0, 1, 3, 0, 1};
`endif
    check("pktCount", obsSrc.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      if (obsSrc.size() > i) check($sformatf("pktSrc%0d", i), obsSrc[i], expSeq[i]);

    $display("[TB] reset in the middle of a packet");
    applyStimulus(4'b0010, 4'b0000, dat(0, 32'h81, 0, 0), 1'b1);
    applyStimulus(4'b1010, 4'b0000, dat(0, 32'h82, 0, 32'h83), 1'b0);
    doReset(4'b1111);
    applyStimulus(4'b1110, 4'b1111, dat(0, 32'h91, 32'h92, 32'h93), 1'b1);
    applyStimulus(4'b1111, 4'b1111, dat(32'h90, 32'h91, 32'h92, 32'h93), 1'b1);
    check("postRstSrc", i0Src, 1);

    $display("[TB] only t3 valid, back-to-back beats");
    for (int i = 0; i < 6; i++)
      applyStimulus(4'b1000, 4'($urandom), dat(0, 0, 0, 32'hC0 + i), 1'b1);
    check("t3Streaming", i0Valid, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(4'($urandom), 4'($urandom),
                    dat($urandom, $urandom, $urandom, $urandom),
                    ($urandom_range(0, 3) != 0));
    applyStimulus(4'b0000, 4'b0000, '0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
